// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the data-memory access controller.
//   size_e        : request size encoding (byte / half / word / reserved)
//   state_e       : controller FSM states
//   lane_extract  : pick the addressed byte/half out of a RAM word and extend it
//   lane_merge    : replace the addressed byte/half of a RAM word with store data
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_LD_WAIT  = 2'b01,
    ST_RMW_WAIT = 2'b10,
    ST_RSP      = 2'b11
  } state_e;

  // Byte lane = off[1:0], half lane = off[1]; words pass through untouched.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input size_e       size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = {{24{~uns & b[7]}}, b};
      SZ_H:    r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input size_e       size,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_B: r[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_H: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: purely combinational lane logic shared by the load-return
// and read-modify-write paths of dmem_access_ctrl.
//   ram_rdata   in  32  word read back from the RAM
//   off         in  2   byte offset of the captured request
//   size        in  2   captured request size
//   uns         in  1   zero-extend (LBU/LHU) instead of sign-extend
//   wdata       in  32  captured store data (low bits significant)
//   load_data   out 32  aligned and extended load result
//   merged_data out 32  RAM word with the addressed lane replaced
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] ram_rdata,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);

  assign load_data   = lane_extract(ram_rdata, off, size, uns);
  assign merged_data = lane_merge(ram_rdata, off, size, wdata);

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: bridge between the load/store pipeline and a single-port
// synchronous data RAM (1-cycle read latency, read-first, no byte enables).
// Sub-word stores are done as read-modify-write; loads are aligned and
// extended; misaligned / reserved-size requests get an error response with
// no RAM access.
// Optional build macro: DMEM_BOUNDS_CHK_EN -- when defined, a request with any
// byte-address bit above the RAM range set is an error; otherwise those bits
// are ignored and the address wraps modulo DEPTH*4.
// Ports:
//   clk, aresetn                       clock, asynchronous active-low reset
//   i_req_valid/o_req_ready            request handshake (ready only in IDLE)
//   i_req_we/size/unsigned/addr/wdata  request fields
//   o_rsp_valid/i_rsp_ready            response handshake
//   o_rsp_rdata/o_rsp_err              response payload
//   o_ram_en/wen/addr/wdata, i_ram_rdata  RAM port
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_ram_en,
  output logic              o_ram_wen,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata
);

  state_e              state_reg, state_next;
  logic [1:0]          off_reg, off_next;
  size_e               size_reg, size_next;
  logic                uns_reg, uns_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [31:0]         wdata_reg, wdata_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic [31:0]         rsp_rdata_reg, rsp_rdata_next;
  logic                rsp_err_reg, rsp_err_next;

  size_e               req_size;
  logic [ADDR_W-1:0]   req_word_addr;
  logic                accept;
  logic                req_oob;
  logic                req_err;
  logic [31:0]         load_data;
  logic [31:0]         merged_data;

  assign req_size      = size_e'(i_req_size);
  assign req_word_addr = i_req_addr[ADDR_W+1:2];
  assign o_req_ready   = (state_reg == ST_IDLE);
  assign accept        = i_req_valid & o_req_ready;

`ifdef DMEM_BOUNDS_CHK_EN
  generate
    if (ADDR_W + 2 < 32) begin : g_bounds
      assign req_oob = |i_req_addr[31:ADDR_W+2];
    end else begin : g_no_bounds
      assign req_oob = 1'b0;
    end
  endgenerate
`else
  // Upper address bits alias onto the RAM; keep them visibly consumed.
  generate
    if (ADDR_W + 2 < 32) begin : g_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = |i_req_addr[31:ADDR_W+2];
    end
  endgenerate
  assign req_oob = 1'b0;
`endif

  assign req_err = (req_size == SZ_RSV)
                 | ((req_size == SZ_H) & i_req_addr[0])
                 | ((req_size == SZ_W) & (i_req_addr[1:0] != 2'b00))
                 | req_oob;

  // One lane unit serves both LD_WAIT and RMW_WAIT; it always works on the
  // captured request, which is stable in both states.
  dmem_lane_unit u_lane (
    .ram_rdata   (i_ram_rdata),
    .off         (off_reg),
    .size        (size_reg),
    .uns         (uns_reg),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= ST_IDLE;
      off_reg       <= 2'b00;
      size_reg      <= SZ_B;
      uns_reg       <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      off_reg       <= off_next;
      size_reg      <= size_next;
      uns_reg       <= uns_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    off_next       = off_reg;
    size_next      = size_reg;
    uns_next       = uns_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    o_ram_en       = 1'b0;
    o_ram_wen      = 1'b0;
    o_ram_addr     = '0;
    o_ram_wdata    = '0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          off_next       = i_req_addr[1:0];
          size_next      = req_size;
          uns_next       = i_req_unsigned;
          addr_next      = req_word_addr;
          wdata_next     = i_req_wdata;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
          if (req_err) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            state_next     = ST_RSP;
          end else if (i_req_we && (req_size == SZ_W)) begin
            // Full-word store needs no read; write straight through.
            o_ram_en       = 1'b1;
            o_ram_wen      = 1'b1;
            o_ram_addr     = req_word_addr;
            o_ram_wdata    = i_req_wdata;
            rsp_valid_next = 1'b1;
            state_next     = ST_RSP;
          end else begin
            // Loads and sub-word stores both start with a read.
            o_ram_en   = 1'b1;
            o_ram_addr = req_word_addr;
            state_next = i_req_we ? ST_RMW_WAIT : ST_LD_WAIT;
          end
        end
      end
      ST_LD_WAIT: begin
        rsp_rdata_next = load_data;
        rsp_valid_next = 1'b1;
        state_next     = ST_RSP;
      end
      ST_RMW_WAIT: begin
        o_ram_en       = 1'b1;
        o_ram_wen      = 1'b1;
        o_ram_addr     = addr_reg;
        o_ram_wdata    = merged_data;
        rsp_valid_next = 1'b1;
        state_next     = ST_RSP;
      end
      ST_RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_next = 1'b0;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_rdata = rsp_rdata_reg;
  assign o_rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: self-checking bench for dmem_access_ctrl with an
// attached read-first single-port RAM and a byte-level reference model.
module tb_dmem_access_ctrl;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);
`ifdef DMEM_BOUNDS_CHK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk;
  logic          aresetn;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic [1:0]    i_req_size;
  logic          i_req_unsigned;
  logic [31:0]   i_req_addr;
  logic [31:0]   i_req_wdata;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [31:0]   o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_ram_en;
  logic          o_ram_wen;
  logic [AW-1:0] o_ram_addr;
  logic [31:0]   o_ram_wdata;
  logic [31:0]   i_ram_rdata;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_err      (o_rsp_err),
    .o_ram_en       (o_ram_en),
    .o_ram_wen      (o_ram_wen),
    .o_ram_addr     (o_ram_addr),
    .o_ram_wdata    (o_ram_wdata),
    .i_ram_rdata    (i_ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached RAM (read-first, 1-cycle latency) with a backdoor preload port.
  logic [31:0]   ram_mem [DEPTH];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [31:0]   poke_data = '0;
  int            n_rd = 0;
  int            n_wr = 0;

  always @(posedge clk) begin
    if (poke_en) begin
      ram_mem[poke_addr] <= poke_data;
    end else if (o_ram_en) begin
      i_ram_rdata <= ram_mem[o_ram_addr];
      if (o_ram_wen) begin
        ram_mem[o_ram_addr] <= o_ram_wdata;
        n_wr <= n_wr + 1;
      end else begin
        n_rd <= n_rd + 1;
      end
    end
  end

  // Reference memory image: what the RAM must hold after each transaction.
  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = AW'(idx);
    poke_data = val;
    ref_mem[idx] = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // One complete transaction: request, latency, response payload, optional
  // back-pressure with a stray request that must be ignored, RAM traffic.
  task automatic do_req(input string tag, input bit we, input logic [1:0] sz,
                        input bit uns, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    bit          e;
    int          nb, ba, widx, sh, lat, rd0, wr0;
    int          exp_lat, exp_rd, exp_wr;
    logic [31:0] mask, word, v, exp_data;

    e = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
        || (BOUNDS && (a >= 32'(4 * DEPTH)));
    nb   = (sz == 2'd3) ? 4 : (1 << sz);
    ba   = int'(a % 32'(4 * DEPTH));
    widx = ba / 4;
    sh   = (ba % 4) * 8;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    word = ref_mem[widx];
    exp_data = 32'd0;
    if (e) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!we) begin
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
      v = (word >> sh) & mask;
      if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
      exp_data = v;
    end else if (nb == 4) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 1;
    end else begin
      exp_lat = 2; exp_rd = 1; exp_wr = 1;
    end

    @(negedge clk);
    chk({tag, "_ready_idle"}, {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1; i_req_we = we; i_req_size = sz;
    i_req_unsigned = uns; i_req_addr = a; i_req_wdata = wd;
    rd0 = n_rd; wr0 = n_wr;
    @(posedge clk); #1;
    // Garbage on the request bus must not matter after the accept.
    i_req_valid = 1'b0; i_req_addr = $urandom; i_req_wdata = $urandom;
    i_req_size = 2'($urandom); i_req_we = 1'($urandom);
    lat = 1;
    while (o_rsp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, {31'd0, o_rsp_err}, {31'd0, e});
    chk({tag, "_rdata"}, o_rsp_rdata, exp_data);
    chk({tag, "_ready_busy"}, {31'd0, o_req_ready}, 32'd0);

    for (int k = 0; k < hold; k++) begin
      if (k == 0) begin
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd2;
        i_req_addr = 32'h0000_0100; i_req_wdata = 32'hBADC_0DE5;
      end
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'd0, o_rsp_valid}, 32'd1);
      chk({tag, "_hold_rdata"}, o_rsp_rdata, exp_data);
      chk({tag, "_hold_ready"}, {31'd0, o_req_ready}, 32'd0);
    end

    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    i_req_valid = 1'b0;
    chk({tag, "_rsp_drop"}, {31'd0, o_rsp_valid}, 32'd0);
    chk({tag, "_rdata_clr"}, o_rsp_rdata, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, o_req_ready}, 32'd1);
    chk({tag, "_ram_reads"}, 32'(n_rd - rd0), 32'(exp_rd));
    chk({tag, "_ram_writes"}, 32'(n_wr - wr0), 32'(exp_wr));

    if (!e && we)
      ref_mem[widx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
    $display("txn %-10s we=%0d size=%0d uns=%0d addr=%h wdata=%h lat=%0d err=%0d rdata=%h",
             tag, we, sz, uns, a, wd, lat, o_rsp_err, exp_data);
  endtask

  initial begin
    int wr0;
    aresetn = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'd0;
    i_req_unsigned = 1'b0; i_req_addr = '0; i_req_wdata = '0; i_rsp_ready = 1'b0;

    // Preload the whole RAM while the controller is held in reset.
    @(negedge clk);
    poke_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      poke_addr = AW'(i);
      poke_data = $urandom;
      ref_mem[i] = poke_data;
      @(negedge clk);
    end
    poke_en = 1'b0;

    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
    chk("rst_ram_en", {31'd0, o_ram_en}, 32'd0);
    chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    @(negedge clk);
    aresetn = 1'b1;

    // Word store then word load.
    do_req("sw_10", 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0);
    chk("sw_10_ram", ram_mem[4], 32'hDEAD_BEEF);
    do_req("lw_10", 0, 2'd2, 0, 32'h10, 32'h0, 0);

    // Byte store via RMW, then signed/unsigned byte loads.
    poke(4, 32'h1122_3344);
    do_req("sb_11", 1, 2'd0, 0, 32'h11, 32'h0000_00A5, 0);
    chk("sb_11_ram", ram_mem[4], 32'h1122_A544);
    do_req("lb_11", 0, 2'd0, 0, 32'h11, 32'h0, 0);
    do_req("lbu_11", 0, 2'd0, 1, 32'h11, 32'h0, 0);

    // Half store into the upper lane, then signed/unsigned half loads.
    do_req("sh_12", 1, 2'd1, 0, 32'h12, 32'hFFFF_8001, 0);
    chk("sh_12_ram", ram_mem[4], 32'h8001_A544);
    do_req("lh_12", 0, 2'd1, 0, 32'h12, 32'h0, 0);
    do_req("lhu_12", 0, 2'd1, 1, 32'h12, 32'h0, 0);

    // Error cases: no RAM traffic, memory untouched.
    do_req("lw_13", 0, 2'd2, 0, 32'h13, 32'h0, 0);
    do_req("sh_01", 1, 2'd1, 0, 32'h01, 32'h1234_5678, 0);
    do_req("rsv_10", 1, 2'd3, 0, 32'h10, 32'h5555_5555, 0);
    chk("err_ram_unchanged", ram_mem[4], 32'h8001_A544);

    // Response back-pressure with a stray request pending.
    do_req("lw_stall", 0, 2'd2, 0, 32'h10, 32'h0, 5);
    do_req("sb_stall", 1, 2'd0, 0, 32'h23, 32'h0000_0077, 5);

    // Reset while the RMW write is being issued.
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd0;
    i_req_unsigned = 1'b0; i_req_addr = 32'h20; i_req_wdata = 32'h0000_00FF;
    wr0 = n_wr;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    chk("rmw_wait_wen", {31'd0, o_ram_wen}, 32'd1);
    #1 aresetn = 1'b0;
    #1;
    chk("arst_ram_en", {31'd0, o_ram_en}, 32'd0);
    chk("arst_ram_wen", {31'd0, o_ram_wen}, 32'd0);
    chk("arst_ram_wdata", o_ram_wdata, 32'd0);
    chk("arst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("arst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("arst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    chk("arst_no_write", 32'(n_wr - wr0), 32'd0);
    chk("arst_ram8", ram_mem[8], ref_mem[8]);
    $display("txn %-10s reset during RMW_WAIT of SB 0xFF to 0x20", "arst_rmw");

    // Out-of-range address: error with bounds checking, alias to word 0 otherwise.
    poke(0, 32'hCAFE_F00D);
    do_req("lw_oob", 0, 2'd2, 0, 32'(4 * DEPTH), 32'h0, 0);

    // Randomised traffic over a small window, some with high address bits.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
      do_req("rand", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a,
             $urandom, $urandom_range(0, 2));
    end

    for (int i = 0; i < 80; i++) begin
      chk("final_ram", ram_mem[i], ref_mem[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
